tag_data_array: RTL and testbench
=================================

# tag_data_array

Parametrised tag+data storage array for the small cache datapath, addressed by one-hot wordline. It adds a per-entry valid bit, tag-compare hit detection, registered responses with a valid/ready request handshake, and a post-reset clear sequencer that invalidates every entry one per cycle. It sits between the cache controller (requester) and the hit/miss logic (response consumer).

## Interface
- DEPTH, 16, number of entries; power of two, ≥2; index width AW = $clog2(DEPTH)
- DATA_W, 8, data word width
- TAG_W, 4, tag width

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  array accepts a request this cycle
- req_we  in  1  1 = write, 0 = read/lookup
- req_wl  in  DEPTH  one-hot wordline select
- req_tag  in  TAG_W  write tag / lookup compare tag
- req_data  in  DATA_W  write data
- req_inv  in  1  invalidate op (present only with TDA_INVALIDATE_EN)
- rsp_valid  out  1  response valid, one cycle pulse per accepted request
- rsp_hit  out  1  entry valid and stored tag == request tag
- rsp_err  out  1  req_wl was not exactly one-hot
- rsp_tag  out  TAG_W  stored tag of selected entry
- rsp_data  out  DATA_W  stored data of selected entry
- busy  out  1  clear sequence in progress

## Operation
- Storage: DEPTH × {valid, TAG_W tag, DATA_W data}. Tag/data contents are undefined after reset; only valid bits are cleared.
- FSM states: CLEAR, READY.
  - reset=1: state←CLEAR, clear index←0, all outputs 0 (rsp_valid, rsp_hit, rsp_err, rsp_tag, rsp_data, req_ready=0, busy=1).
  - CLEAR: each cycle valid[index]←0, index++; at index==DEPTH-1 go to READY. busy=1, req_ready=0.
  - READY: req_ready=1, busy=0; stays until reset.
- Accept: req_valid && req_ready at a rising edge.
- Wordline decode: exactly one bit set → index = its position; else rsp_err=1, no state change, rsp_hit=0, rsp_tag=0, rsp_data=0.
- Read: rsp_tag/rsp_data = stored entry; rsp_hit = valid && stored tag == req_tag.
- Write: entry ← {1, req_tag, req_data}; response is write-through: rsp_tag=req_tag, rsp_data=req_data, rsp_hit=1.
- req_inv (macro on): valid[index]←0; rsp_hit=0, rsp_tag/rsp_data = prior contents. req_inv has priority over req_we.
- Response fields hold last value when rsp_valid=0; consumers sample only on rsp_valid.

## Timing
- Clear: exactly DEPTH cycles after the first cycle with reset=0; req_ready rises on cycle DEPTH+1.
- Latency: response registered, rsp_valid=1 in the cycle after acceptance. Throughput one request/cycle.
- Back-to-back write then read of the same entry: read returns new tag/data, hit=1.
- No backpressure on responses; rsp_valid not gated by any ready.
- Reset mid-operation: in-flight response dropped (rsp_valid=0 next cycle), clear restarts at index 0.
- Requests during CLEAR are ignored (req_ready=0); no response generated.

## Configuration
- TDA_INVALIDATE_EN defined: req_inv port present, single-entry invalidate supported as above.
- Undefined: port absent; only read and write ops; valid bits cleared only by the reset sequence.

## Test plan
- Reset 2 cycles, DEPTH=16 → busy=1, req_ready=0 for 16 cycles after reset falls, then req_ready=1, busy=0.
- After clear, read wl=16'h0001 tag=4'h3 → next cycle rsp_valid=1, rsp_hit=0, rsp_err=0.
- Write wl=16'h0020 tag=4'hA data=8'h5C, then read wl=16'h0020 tag=4'hA next cycle → write rsp data=8'h5C hit=1; read rsp data=8'h5C tag=4'hA hit=1; read with tag=4'hB → hit=0, data=8'h5C.
- Request with wl=16'h0000 and wl=16'h0011 (we=1) → rsp_err=1, hit=0, data=0; subsequent reads of entries 0 and 4 unchanged.
- Write entry 7, assert reset during the following read request → no rsp_valid, 16-cycle clear, then read entry 7 → hit=0.
- TDA_INVALIDATE_EN: write entry 3 tag=4'h1 data=8'hF0, inv entry 3, read entry 3 tag=4'h1 → inv rsp hit=0 data=8'hF0; read hit=0.

Source files
------------

// File: rtl/tag_data_array_if.sv
// Request/response bundle between the cache controller and tag_data_array.
// The req_inv wire exists only when TDA_INVALIDATE_EN is defined.
interface tag_data_array_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [DEPTH-1:0]  req_wl;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_data;
`ifdef TDA_INVALIDATE_EN
    logic              req_inv;
`endif
    logic              rsp_valid;
    logic              rsp_hit;
    logic              rsp_err;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

`ifdef TDA_INVALIDATE_EN
    modport master (
        output req_valid, req_we, req_wl, req_tag, req_data, req_inv,
        input  req_ready, rsp_valid, rsp_hit, rsp_err, rsp_tag, rsp_data, busy
    );
    modport slave (
        input  req_valid, req_we, req_wl, req_tag, req_data, req_inv,
        output req_ready, rsp_valid, rsp_hit, rsp_err, rsp_tag, rsp_data, busy
    );
`else
    modport master (
        output req_valid, req_we, req_wl, req_tag, req_data,
        input  req_ready, rsp_valid, rsp_hit, rsp_err, rsp_tag, rsp_data, busy
    );
    modport slave (
        input  req_valid, req_we, req_wl, req_tag, req_data,
        output req_ready, rsp_valid, rsp_hit, rsp_err, rsp_tag, rsp_data, busy
    );
`endif
endinterface

// File: rtl/tag_data_array.sv
// One-hot addressed tag+data array with valid bits, tag-compare hit and a post-reset clear sequencer.
// Optional single-entry invalidate op is enabled by defining TDA_INVALIDATE_EN.
module tag_data_array #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    tag_data_array_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t            r_state, w_state_nxt;
    logic [AW-1:0]     r_clr_idx, w_clr_idx_nxt;
    logic              w_req_ready, w_busy;

    logic [DEPTH-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic              r_rsp_valid, r_rsp_hit, r_rsp_err;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic [DATA_W-1:0] r_rsp_data;

    logic [AW-1:0]     w_idx;
    logic              w_onehot, w_acc, w_inv;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_req_ready   = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy        = 1'b1;
                w_clr_idx_nxt = r_clr_idx + AW'(1);
                if (r_clr_idx == AW'(DEPTH - 1)) w_state_nxt = ST_READY;
            end
            ST_READY: w_req_ready = 1'b1;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Wordline decode; the index is only meaningful when exactly one bit is set.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.req_wl[i]) w_idx = AW'(i);
        end
    end

    assign w_onehot = (bus.req_wl != '0) && ((bus.req_wl & (bus.req_wl - DEPTH'(1))) == '0);
    assign w_acc    = bus.req_valid && w_req_ready && !reset;

`ifdef TDA_INVALIDATE_EN
    assign w_inv = bus.req_inv;
`else
    assign w_inv = 1'b0;
`endif

    // Storage is not reset; the clear sequencer walks the valid bits instead.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_valid[r_clr_idx] <= 1'b0;
        end else if (w_acc && w_onehot) begin
            if (w_inv) begin
                r_valid[w_idx] <= 1'b0;
            end else if (bus.req_we) begin
                r_valid[w_idx] <= 1'b1;
                r_tag[w_idx]   <= bus.req_tag;
                r_data[w_idx]  <= bus.req_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_tag   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_acc;
            if (w_acc) begin
                if (!w_onehot) begin
                    r_rsp_err  <= 1'b1;
                    r_rsp_hit  <= 1'b0;
                    r_rsp_tag  <= '0;
                    r_rsp_data <= '0;
                end else if (w_inv) begin
                    r_rsp_err  <= 1'b0;
                    r_rsp_hit  <= 1'b0;
                    r_rsp_tag  <= r_tag[w_idx];
                    r_rsp_data <= r_data[w_idx];
                end else if (bus.req_we) begin
                    r_rsp_err  <= 1'b0;
                    r_rsp_hit  <= 1'b1;
                    r_rsp_tag  <= bus.req_tag;
                    r_rsp_data <= bus.req_data;
                end else begin
                    r_rsp_err  <= 1'b0;
                    r_rsp_hit  <= r_valid[w_idx] && (r_tag[w_idx] == bus.req_tag);
                    r_rsp_tag  <= r_tag[w_idx];
                    r_rsp_data <= r_data[w_idx];
                end
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.busy      = w_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_hit   = r_rsp_hit;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_tag   = r_rsp_tag;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_tag_data_array.sv
// Self-checking bench for tag_data_array: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an array-based behavioural model.
module tb_tag_data_array;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    tag_data_array_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    tag_data_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endfunction

    // Behavioural model: what the outputs must be after each rising edge.
    logic              m_valid [DEPTH];
    logic [TAG_W-1:0]  m_tag   [DEPTH];
    logic [DATA_W-1:0] m_data  [DEPTH];
    logic              m_known [DEPTH];
    int                m_cnt = 0;
    logic              started = 1'b0;
    logic              e_vld, e_hit, e_err, e_fields, e_known;
    logic [TAG_W-1:0]  e_tag;
    logic [DATA_W-1:0] e_data;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    end

    always @(posedge clk) begin
        logic acc, inv;
        int   idx;
        if (reset) begin
            m_cnt = 0;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            e_vld = 0; e_hit = 0; e_err = 0; e_tag = '0; e_data = '0;
            e_fields = 1; e_known = 1;
            started = 1'b1;
        end else if (started) begin
            acc = bus.req_valid && (m_cnt >= DEPTH);
`ifdef TDA_INVALIDATE_EN
            inv = bus.req_inv;
`else
            inv = 1'b0;
`endif
            if (m_cnt < DEPTH) m_cnt++;
            e_vld = acc;
            e_fields = acc;
            if (acc) begin
                if ($countones(bus.req_wl) != 1) begin
                    e_err = 1; e_hit = 0; e_tag = '0; e_data = '0; e_known = 1;
                end else begin
                    idx = 0;
                    for (int i = 0; i < DEPTH; i++) if (bus.req_wl[i]) idx = i;
                    e_err = 0;
                    if (inv) begin
                        e_hit = 0; e_tag = m_tag[idx]; e_data = m_data[idx];
                        e_known = m_known[idx];
                        m_valid[idx] = 0;
                    end else if (bus.req_we) begin
                        m_valid[idx] = 1; m_tag[idx] = bus.req_tag;
                        m_data[idx] = bus.req_data; m_known[idx] = 1;
                        e_hit = 1; e_tag = bus.req_tag; e_data = bus.req_data; e_known = 1;
                    end else begin
                        e_hit = m_valid[idx] && (m_tag[idx] == bus.req_tag);
                        e_tag = m_tag[idx]; e_data = m_data[idx]; e_known = m_known[idx];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("req_ready", bus.req_ready, (m_cnt >= DEPTH));
            chk("busy", bus.busy, (m_cnt < DEPTH));
            chk("rsp_valid", bus.rsp_valid, e_vld);
            if (e_fields) begin
                chk("rsp_err", bus.rsp_err, e_err);
                chk("rsp_hit", bus.rsp_hit, e_hit);
                if (e_known) begin
                    chk("rsp_tag", bus.rsp_tag, e_tag);
                    chk("rsp_data", bus.rsp_data, e_data);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic inv, input logic [DEPTH-1:0] wl,
                         input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_wl    = wl;
        bus.req_tag   = tag;
        bus.req_data  = data;
`ifdef TDA_INVALIDATE_EN
        bus.req_inv   = inv;
`else
        if (inv) $display("note: invalidate requested in a build without it");
`endif
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_clear(string nm);
        for (int i = 0; i < DEPTH; i++) begin
            chk({nm, "_busy"}, bus.busy, 1'b1);
            chk({nm, "_notready"}, bus.req_ready, 1'b0);
            step();
        end
        chk({nm, "_ready"}, bus.req_ready, 1'b1);
        chk({nm, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        logic [DEPTH-1:0] wl;
        logic             inv;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        reset = 1'b0;
        check_clear("clear1");

        // Read of a freshly cleared entry misses.
        drive(1, 0, 0, 16'h0001, 4'h3, 8'h00); step(); idle();
        chk("rd0_valid", bus.rsp_valid, 1'b1);
        chk("rd0_hit", bus.rsp_hit, 1'b0);
        chk("rd0_err", bus.rsp_err, 1'b0);

        // Write followed back-to-back by reads of the same entry.
        drive(1, 1, 0, 16'h0020, 4'hA, 8'h5C); step();
        drive(1, 0, 0, 16'h0020, 4'hA, 8'h00);
        chk("wr5_hit", bus.rsp_hit, 1'b1);
        chk("wr5_data", bus.rsp_data, 8'h5C);
        step();
        drive(1, 0, 0, 16'h0020, 4'hB, 8'h00);
        chk("rd5_hit", bus.rsp_hit, 1'b1);
        chk("rd5_tag", bus.rsp_tag, 4'hA);
        chk("rd5_data", bus.rsp_data, 8'h5C);
        step(); idle();
        chk("rd5b_hit", bus.rsp_hit, 1'b0);
        chk("rd5b_data", bus.rsp_data, 8'h5C);

        // Malformed wordlines report an error and leave the array alone.
        drive(1, 1, 0, 16'h0000, 4'h7, 8'hFF); step();
        drive(1, 1, 0, 16'h0011, 4'h7, 8'hFF);
        chk("err0_err", bus.rsp_err, 1'b1);
        chk("err0_data", bus.rsp_data, 8'h00);
        step();
        drive(1, 0, 0, 16'h0001, 4'h7, 8'h00);
        chk("err1_err", bus.rsp_err, 1'b1);
        chk("err1_hit", bus.rsp_hit, 1'b0);
        chk("err1_data", bus.rsp_data, 8'h00);
        step();
        drive(1, 0, 0, 16'h0010, 4'h7, 8'h00);
        chk("e0_hit", bus.rsp_hit, 1'b0);
        chk("e0_err", bus.rsp_err, 1'b0);
        step(); idle();
        chk("e4_hit", bus.rsp_hit, 1'b0);

        // Reset arriving with a read in flight drops it and restarts the clear.
        drive(1, 1, 0, 16'h0080, 4'h5, 8'h33); step();
        drive(1, 0, 0, 16'h0080, 4'h5, 8'h00);
        reset = 1'b1;
        step();
        reset = 1'b0; idle();
        chk("rstmid_valid", bus.rsp_valid, 1'b0);
        check_clear("clear2");
        drive(1, 0, 0, 16'h0080, 4'h5, 8'h00); step(); idle();
        chk("e7_valid", bus.rsp_valid, 1'b1);
        chk("e7_hit", bus.rsp_hit, 1'b0);

`ifdef TDA_INVALIDATE_EN
        drive(1, 1, 0, 16'h0008, 4'h1, 8'hF0); step();
        drive(1, 0, 1, 16'h0008, 4'h1, 8'h00); step();
        drive(1, 0, 0, 16'h0008, 4'h1, 8'h00);
        chk("inv_hit", bus.rsp_hit, 1'b0);
        chk("inv_data", bus.rsp_data, 8'hF0);
        step(); idle();
        chk("rdinv_hit", bus.rsp_hit, 1'b0);
`endif

        // Randomized traffic, including requests during clear and occasional resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 8) begin
                wl = DEPTH'(1) << $urandom_range(0, DEPTH - 1);
            end else begin
                wl = DEPTH'($urandom);
            end
`ifdef TDA_INVALIDATE_EN
            inv = ($urandom_range(0, 9) == 0);
`else
            inv = 1'b0;
`endif
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, inv, wl,
                  TAG_W'($urandom_range(0, 3)), DATA_W'($urandom));
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
